// File: rtl/gpio_input_if.sv
// ---------------------------------------------------------------------------
// gpio_input_if
// Memory-stage access bus shared by the D-Cache / GPIO blocks.
//   uop      : micro-op code (LDR / STR encodings are parameters of the
//              consumer; every other code is ignored)
//   addr     : byte address of the access
//   data_in  : store data
//   data_out : registered load data returned by the slave
//   rd_hit   : slave claimed the previous-edge load
// ---------------------------------------------------------------------------
interface gpio_input_if;
  logic [3:0]  uop;
  logic [31:0] addr;
  logic [31:0] data_in;
  logic [31:0] data_out;
  logic        rd_hit;

  modport master (output uop, addr, data_in, input  data_out, rd_hit);
  modport slave  (input  uop, addr, data_in, output data_out, rd_hit);
endinterface

// File: rtl/gpio_input.sv
// ---------------------------------------------------------------------------
// gpio_input
// Read-side GPIO block: synchronizes WIDTH async pins, optionally debounces
// them, latches rising edges into sticky W1C flags and returns the level or
// the flags on an LDR. All state changes on negedge clk, like the write-side
// GPIO on the same memory stage.
//
// Ports
//   i_clk     : system clock (negedge active)
//   i_rst     : synchronous active-high reset, sampled on negedge
//   bus       : gpio_input_if.slave (uop/addr/data_in in, data_out/rd_hit out)
//   i_pins_in : asynchronous external inputs
//   o_irq     : OR of all edge flags
//
// Build option
//   GPIO_DEBOUNCE_EN : per-pin stability counters before the level register
//                      may change. Undefined -> level follows the synchronizer.
// ---------------------------------------------------------------------------
module gpio_input #(
  parameter int          WIDTH           = 32,
  parameter int          SYNC_STAGES     = 2,
  parameter int          DEBOUNCE_CYCLES = 4,
  parameter logic [31:0] ADDR_LEVEL      = 32'd36,
  parameter logic [31:0] ADDR_EDGE       = 32'd40,
  parameter logic [3:0]  UOP_LDR         = 4'h1,
  parameter logic [3:0]  UOP_STR         = 4'h2
) (
  input  logic             i_clk,
  input  logic             i_rst,
  gpio_input_if.slave      bus,
  input  logic [WIDTH-1:0] i_pins_in,
  output logic             o_irq
);

  logic [SYNC_STAGES-1:0][WIDTH-1:0] r_sync;
  logic [WIDTH-1:0] r_lvl, r_flags;
  logic [WIDTH-1:0] w_sync, w_lvl_nxt, w_rise, w_clr;
  logic [31:0]      w_lvl32, w_flags32, r_dout;
  logic             r_hit, w_ldr, w_str_edge;

  assign w_sync     = r_sync[SYNC_STAGES-1];
  assign w_ldr      = (bus.uop == UOP_LDR);
  assign w_str_edge = (bus.uop == UOP_STR) && (bus.addr == ADDR_EDGE);
  assign w_rise     = w_lvl_nxt & ~r_lvl;

  always_comb begin
    w_clr     = w_str_edge ? bus.data_in[WIDTH-1:0] : '0;
    w_lvl32   = '0;
    w_flags32 = '0;
    w_lvl32[WIDTH-1:0]   = r_lvl;
    w_flags32[WIDTH-1:0] = r_flags;
  end

`ifdef GPIO_DEBOUNCE_EN
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  // Counter tracks how many consecutive edges sync has disagreed with lvl;
  // the DEBOUNCE_CYCLES-th disagreeing edge flips the level.
  for (genvar g = 0; g < WIDTH; g++) begin : g_dbnc
    logic [CW-1:0] r_cnt;
    logic          w_diff, w_fire;
    assign w_diff       = w_sync[g] ^ r_lvl[g];
    assign w_fire       = w_diff && (r_cnt == CNT_LAST);
    assign w_lvl_nxt[g] = r_lvl[g] ^ w_fire;
    always_ff @(negedge i_clk) begin
      if (i_rst)                r_cnt <= '0;
      else if (!w_diff || w_fire) r_cnt <= '0;
      else                      r_cnt <= r_cnt + 1'b1;
    end
  end
`else
  assign w_lvl_nxt = w_sync;
`endif

  always_ff @(negedge i_clk) begin
    if (i_rst) begin
      r_sync  <= '0;
      r_lvl   <= '0;
      r_flags <= '0;
      r_dout  <= '0;
      r_hit   <= 1'b0;
    end else begin
      r_sync  <= {r_sync[SYNC_STAGES-2:0], i_pins_in};
      r_lvl   <= w_lvl_nxt;
      // set wins over a same-edge W1C of the same bit
      r_flags <= (r_flags & ~w_clr) | w_rise;
      // reads return pre-edge register values; misses hold data_out
      if (w_ldr && bus.addr == ADDR_LEVEL) begin
        r_dout <= w_lvl32;
        r_hit  <= 1'b1;
      end else if (w_ldr && bus.addr == ADDR_EDGE) begin
        r_dout <= w_flags32;
        r_hit  <= 1'b1;
      end else begin
        r_hit  <= 1'b0;
      end
    end
  end

  assign bus.data_out = r_dout;
  assign bus.rd_hit   = r_hit;
  assign o_irq        = |r_flags;

endmodule

// File: tb/tb_gpio_input.sv
// ---------------------------------------------------------------------------
// tb_gpio_input : directed bench for gpio_input with a queue-based pin model
// compared on every posedge, plus literal expectations on the directed reads.
// ---------------------------------------------------------------------------
module tb_gpio_input;
  localparam int SYNC = 2;
  localparam int DEB  = 4;
`ifdef GPIO_DEBOUNCE_EN
  localparam int LAT = SYNC + DEB;
`else
  localparam int LAT = SYNC + 1;
`endif
  localparam logic [3:0] NOP = 4'h0, LDR = 4'h1, STR = 4'h2;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] pins;
  logic        irq;
  int          n_chk = 0, n_pass = 0;

  gpio_input_if bus();

  gpio_input #(.WIDTH(32), .SYNC_STAGES(SYNC), .DEBOUNCE_CYCLES(DEB),
               .ADDR_LEVEL(32'd36), .ADDR_EDGE(32'd40),
               .UOP_LDR(LDR), .UOP_STR(STR))
    dut (.i_clk(clk), .i_rst(rst), .bus(bus), .i_pins_in(pins), .o_irq(irq));

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
  endtask

  // ---------------- behavioural model ----------------
  // lvl is the pin sample taken SYNC edges earlier (queue delay line),
  // optionally held until it has disagreed for DEB consecutive edges.
  logic [31:0] m_lvl, m_flags, m_dout, m_s, m_nl, m_clr;
  logic        m_hit;
  bit          m_ok = 0;
  logic [31:0] m_hist[$];
  int          m_cnt[32];

  always @(negedge clk) begin
    if (rst) begin
      m_lvl = '0; m_flags = '0; m_dout = '0; m_hit = 1'b0;
      m_hist.delete();
      for (int i = 0; i < SYNC; i++) m_hist.push_back('0);
      for (int i = 0; i < 32; i++) m_cnt[i] = 0;
      m_ok = 1;
    end else if (m_ok) begin
      m_s = m_hist.pop_front();
      m_hist.push_back(pins);
`ifdef GPIO_DEBOUNCE_EN
      m_nl = m_lvl;
      for (int i = 0; i < 32; i++) begin
        if (m_s[i] != m_lvl[i]) begin
          m_cnt[i]++;
          if (m_cnt[i] == DEB) begin m_nl[i] = m_s[i]; m_cnt[i] = 0; end
        end else m_cnt[i] = 0;
      end
`else
      m_nl = m_s;
`endif
      m_clr = (bus.uop == STR && bus.addr == 32'd40) ? bus.data_in : '0;
      if (bus.uop == LDR && bus.addr == 32'd36)      begin m_dout = m_lvl;   m_hit = 1'b1; end
      else if (bus.uop == LDR && bus.addr == 32'd40) begin m_dout = m_flags; m_hit = 1'b1; end
      else m_hit = 1'b0;
      m_flags = (m_flags & ~m_clr) | (m_nl & ~m_lvl);
      m_lvl   = m_nl;
    end
  end

  always @(posedge clk) if (m_ok) begin
    chk("model data_out", bus.data_out, m_dout);
    chk("model rd_hit", {31'b0, bus.rd_hit}, {31'b0, m_hit});
    chk("model irq", {31'b0, irq}, {31'b0, |m_flags});
  end

  // ---------------- directed stimulus ----------------
  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic ldr(input logic [31:0] a);
    bus.uop = LDR; bus.addr = a; cyc(1);
    bus.uop = NOP;
  endtask

  task automatic str(input logic [31:0] a, input logic [31:0] d);
    bus.uop = STR; bus.addr = a; bus.data_in = d; cyc(1);
    bus.uop = NOP; bus.data_in = '0;
  endtask

  initial begin
    rst = 1'b1; pins = 32'hFFFF_FFFF;
    bus.uop = NOP; bus.addr = '0; bus.data_in = '0;
    @(posedge clk); #1;
    cyc(2);
    chk("reset data_out", bus.data_out, 32'h0);
    chk("reset rd_hit", {31'b0, bus.rd_hit}, 32'h0);
    chk("reset irq", {31'b0, irq}, 32'h0);
    rst = 1'b0;

    // pins high through reset -> one rising edge on every bit
    cyc(LAT + 1);
    ldr(36); chk("post-reset level", bus.data_out, 32'hFFFF_FFFF);
    chk("post-reset rd_hit", {31'b0, bus.rd_hit}, 32'h1);
    ldr(40); chk("post-reset flags", bus.data_out, 32'hFFFF_FFFF);
    chk("post-reset irq", {31'b0, irq}, 32'h1);
    str(40, 32'hFFFF_FFFF); chk("clear-all irq", {31'b0, irq}, 32'h0);
    pins = '0; cyc(LAT + 1);
    ldr(40); chk("falls set no flags", bus.data_out, 32'h0);

    // rise then fall on bit3
    pins = 32'h8; cyc(LAT);
    ldr(40); chk("bit3 rise flag", bus.data_out, 32'h8);
    chk("bit3 irq", {31'b0, irq}, 32'h1);
    pins = '0; cyc(LAT + 1);
    ldr(40); chk("bit3 fall keeps flag", bus.data_out, 32'h8);
    ldr(36); chk("bit3 level low", bus.data_out, 32'h0);
    str(40, 32'h8); chk("w1c irq drop", {31'b0, irq}, 32'h0);
    ldr(40); chk("w1c flags", bus.data_out, 32'h0);

    // bit0 rise lands on the same edge as its W1C
    pins = 32'h1; cyc(LAT - 1);
    str(40, 32'h1);
    ldr(40); chk("collision set wins", bus.data_out, 32'h1);

    // unmatched accesses
    ldr(32);
    chk("miss rd_hit", {31'b0, bus.rd_hit}, 32'h0);
    chk("miss data_out held", bus.data_out, 32'h1);
    str(36, 32'hFFFF_FFFF);
    ldr(40); chk("str level no effect", bus.data_out, 32'h1);

    pins = '0; cyc(LAT + 1);
    str(40, 32'hFFFF_FFFF); chk("cleanup irq", {31'b0, irq}, 32'h0);

`ifdef GPIO_DEBOUNCE_EN
    pins = 32'h2; cyc(3); pins = '0; cyc(LAT + 2);
    ldr(36); chk("3-cycle glitch level", bus.data_out, 32'h0);
    ldr(40); chk("3-cycle glitch flags", bus.data_out, 32'h0);
    pins = 32'h2; cyc(4); pins = '0; cyc(2);
    ldr(36); chk("4-cycle pulse level", bus.data_out, 32'h2);
    ldr(40); chk("4-cycle pulse flags", bus.data_out, 32'h2);
`else
    pins = 32'h2; cyc(1); pins = '0; cyc(LAT + 1);
    ldr(40); chk("1-cycle pulse flag", bus.data_out, 32'h2);
    ldr(36); chk("1-cycle pulse level", bus.data_out, 32'h0);
`endif
    cyc(LAT + 2);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, passed %0d of %0d", n_pass, n_chk);
    $fatal(1);
  end
endmodule
